instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the control/opcode decoding path. Accepts an instruction class plus fields (rd, rs1, rs2, funct3, funct7b5, imm) over a valid/ready stream.
- Packs each accepted instruction into a 32-bit RV32I word and writes it sequentially into instruction memory from a base address.
- Used as a program loader and test-program builder ahead of the single-cycle core.

Parameters:
- ADDR_W, 10, word-address width of the instruction memory write port.
- CNT_W, 10, width of the instruction-count input and its internal counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse that begins a load session; ignored unless the FSM is in IDLE
- base_addr  input  ADDR_W  first word address; sampled on start
- count  input  CNT_W  number of legal instructions to write; sampled on start
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- in_class  input  4  instruction class (instr_class_t)
- rd, rs1, rs2  input  5 each  register fields
- funct3  input  3  funct3 field
- funct7b5  input  1  funct7 bit 5 (R-type, and I-type shifts)
- imm  input  32  signed immediate; the byte offset for BRANCH/JAL, the upper value already shifted for LUI/AUIPC
- imem_we  output  1  instruction memory write strobe
- imem_addr  output  ADDR_W  write word address
- imem_wdata  output  32  encoded instruction
- busy  output  1  FSM not in IDLE
- done  output  1  one-cycle pulse after the last write
- err_illegal  output  1  sticky flag, cleared on start

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, in_ready=0, busy=0, done=0, err_illegal=0. FSM goes to IDLE. Reset overrides everything, including a session in progress; a write pending in the output register is dropped.
- FSM states:
  - IDLE -> LOAD on start with count!=0.
  - IDLE -> DONE on start with count==0.
  - LOAD -> FLUSH when a legal bundle is accepted and remaining==1.
  - FLUSH -> DONE after one cycle.
  - DONE -> IDLE after one cycle.
- in_ready=1 only in LOAD. A bundle is accepted on the cycle where in_valid & in_ready.
- Latency: a bundle accepted in cycle N produces imem_we=1 in cycle N+1, with the registered word and address. One write per cycle is sustained.
- imem_addr starts at base_addr and increments by 1 per write, wrapping modulo 2^ADDR_W.
- remaining is loaded from count on start and decrements on each legal accept.
- Opcodes: R 0110011, I_ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Field packing:
  - R: {0,funct7b5,00000,rs2,rs1,funct3,rd,op}.
  - I_ALU: imm[11:0]; when funct3=001 or 101, bits[31:25] are replaced by {0,funct7b5,00000}.
  - LOAD: imm[11:0], rs1, funct3, rd.
  - JALR: imm[11:0], rs1, funct3 forced to 000, rd.
  - STORE: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - LUI/AUIPC: {imm[31:12],rd,op}.
  - Immediate bits not listed are ignored.
- Illegal in_class (outside the nine classes): the bundle is accepted but not written and not counted, and err_illegal is set.
- start while busy is ignored.
- done pulses in the DONE cycle, which is the cycle after the final imem_we.

Optional Feature:
- Macro ENCODER_IMM_CHECK_EN.
- When defined, adds output err_range (sticky, cleared on start). It is set when the immediate does not fit its encoding:
  - I/LOAD/STORE/JALR: not sign-representable in 12 bits.
  - BRANCH: not in 13 bits, or imm[0]=1.
  - JAL: not in 21 bits, or imm[0]=1.
  - LUI/AUIPC: imm[11:0]!=0.
- A range-failing word is still written, truncated as above.
- When undefined, no err_range port and no check logic.

Decomposition:
- Package encoder_pkg:
  - instr_class_t enum (R=0, I_ALU=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8).
  - Opcode localparams.
  - FSM state enum.
- Sub-module instr_field_pack: purely combinational class+fields -> {word, legal}. The top level holds the FSM, counters and output register.

Test Plan:
- start base=0x010, count=1; R add rd=3, rs1=1, rs2=2, f3=000, f7b5=0 -> imem_we next cycle, addr 0x010, wdata 0x002081B3; done one cycle later.
- Back-to-back stream count=3: I_ALU addi x1,x0,5; STORE sw x2,8(x1) f3=010; BRANCH beq x1,x2,+8 -> wdata 0x00500093, 0x0020A423, 0x00208463 at consecutive addresses with no bubbles.
- JAL rd=1, imm=16 -> 0x010000EF; LUI rd=5, imm=0x12345000 -> 0x123452B7.
- in_class=15 mid-stream, count=2 -> no write for that bundle, err_illegal=1, session still finishes after 2 legal writes; next start clears err_illegal.
- base=0x3FF, count=2 -> writes to 0x3FF then 0x000. A start during LOAD is ignored.
- Reset asserted during LOAD -> next cycle all outputs zero, state IDLE. With ENCODER_IMM_CHECK_EN, BRANCH imm=3 sets err_range.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared types for the instruction encoder: instruction classes, RV32I opcodes, FSM states.
package encoder_pkg;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I_ALU  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: instruction class + fields -> RV32I word and legal flag.
// ENCODER_IMM_CHECK_EN adds range_err, flagging immediates that do not fit their encoding.
module instr_field_pack
  import encoder_pkg::*;
(
  input  logic [3:0]  in_class,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
`ifdef ENCODER_IMM_CHECK_EN
  output logic        range_err,
`endif
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = 32'd0;
    legal = 1'b1;
    case (in_class)
      CLS_R:      word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
      CLS_I_ALU: begin
        // Shift-immediate forms carry funct7 in the upper bits instead of imm[11:5].
        if (funct3 == 3'b001 || funct3 == 3'b101)
          word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_I_ALU};
        else
          word = {imm[11:0], rs1, funct3, rd, OP_I_ALU};
      end
      CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      CLS_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      CLS_LUI:    word = {imm[31:12], rd, OP_LUI};
      CLS_AUIPC:  word = {imm[31:12], rd, OP_AUIPC};
      default:    legal = 1'b0;
    endcase
  end

`ifdef ENCODER_IMM_CHECK_EN
  // A value fits in N signed bits when bits [31:N-1] are all copies of the sign.
  logic fits12, fits13, fits21;
  assign fits12 = (imm[31:11] == {21{imm[31]}});
  assign fits13 = (imm[31:12] == {20{imm[31]}});
  assign fits21 = (imm[31:20] == {12{imm[31]}});

  always_comb begin
    range_err = 1'b0;
    case (in_class)
      CLS_I_ALU, CLS_LOAD, CLS_STORE, CLS_JALR: range_err = !fits12;
      CLS_BRANCH:                               range_err = !fits13 || imm[0];
      CLS_JAL:                                  range_err = !fits21 || imm[0];
      CLS_LUI, CLS_AUIPC:                       range_err = (imm[11:0] != 12'd0);
      default:                                  range_err = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes a valid/ready stream of field bundles into RV32I words written sequentially to imem.
// Optional ENCODER_IMM_CHECK_EN adds the sticky err_range output.
module instr_encoder
  import encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
`ifdef ENCODER_IMM_CHECK_EN
  output logic              err_range,
`endif
  output state_t            dbg_state
);

  // Handshake: a bundle transfers on any cycle with in_valid && in_ready; in_ready depends only on state.
  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  remaining;
  logic [31:0]       word;
  logic              legal, accept, wr, start_ok;
`ifdef ENCODER_IMM_CHECK_EN
  logic              range_err;
`endif

  instr_field_pack u_pack (
    .in_class (in_class),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .imm      (imm),
`ifdef ENCODER_IMM_CHECK_EN
    .range_err(range_err),
`endif
    .word     (word),
    .legal    (legal)
  );

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign wr        = accept && legal;
  assign start_ok  = start && (state == S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (count != '0) ? S_LOAD : S_DONE;
      S_LOAD:  if (wr && remaining == CNT_W'(1)) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
      wr_addr     <= '0;
      remaining   <= '0;
      err_illegal <= 1'b0;
`ifdef ENCODER_IMM_CHECK_EN
      err_range   <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      imem_we <= wr;
      if (wr) begin
        imem_addr  <= wr_addr;
        imem_wdata <= word;
        wr_addr    <= wr_addr + 1'b1;
        remaining  <= remaining - 1'b1;
      end
      if (start_ok) begin
        wr_addr     <= base_addr;
        remaining   <= count;
        err_illegal <= 1'b0;
      end else if (accept && !legal) begin
        err_illegal <= 1'b1;
      end
`ifdef ENCODER_IMM_CHECK_EN
      if (start_ok) err_range <= 1'b0;
      else if (wr && range_err) err_range <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed RV32I words; ENCODER_IMM_CHECK_EN also exercises err_range.
module tb_instr_encoder;
  import encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, funct7b5;
  logic [9:0]  base_addr, count, imem_addr;
  logic [3:0]  in_class;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm, imem_wdata;
  logic        imem_we, busy, done, err_illegal;
`ifdef ENCODER_IMM_CHECK_EN
  logic        err_range;
`endif
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.ADDR_W(10), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err_illegal(err_illegal),
`ifdef ENCODER_IMM_CHECK_EN
    .err_range(err_range),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                       input logic [31:0] im);
    in_valid = 1'b1; in_class = c; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7b5 = f7; imm = im;
  endtask

  task automatic begin_session(input logic [9:0] b, input logic [9:0] n);
    start = 1'b1; base_addr = b; count = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    in_class = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7b5 = 1'b0; imm = '0;
    tick(); tick();
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    reset = 1'b0;
    tick();

    // Single R-type add
    begin_session(10'h010, 10'd1);
    check("t1_ready", 32'(in_ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    drive(CLS_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0);
    tick(); in_valid = 1'b0;
    check("t1_we", 32'(imem_we), 32'd1);
    check("t1_addr", 32'(imem_addr), 32'h010);
    check("t1_wdata", imem_wdata, 32'h002081B3);
    check("t1_done_early", 32'(done), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_we_off", 32'(imem_we), 32'd0);
    tick();
    check("t1_idle", 32'(busy), 32'd0);

    // Back-to-back addi / sw / beq
    begin_session(10'h020, 10'd3);
    drive(CLS_I_ALU, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    tick();
    check("t2_we0", 32'(imem_we), 32'd1);
    check("t2_addr0", 32'(imem_addr), 32'h020);
    check("t2_wdata0", imem_wdata, 32'h00500093);
    drive(CLS_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8);
    tick();
    check("t2_we1", 32'(imem_we), 32'd1);
    check("t2_addr1", 32'(imem_addr), 32'h021);
    check("t2_wdata1", imem_wdata, 32'h0020A423);
    drive(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8);
    tick(); in_valid = 1'b0;
    check("t2_we2", 32'(imem_we), 32'd1);
    check("t2_addr2", 32'(imem_addr), 32'h022);
    check("t2_wdata2", imem_wdata, 32'h00208463);
    check("t2_ready_flush", 32'(in_ready), 32'd0);
    tick();
    check("t2_done", 32'(done), 32'd1);
    tick();

    // JAL, LUI, srai (upper imm bits must be replaced by funct7)
    begin_session(10'h040, 10'd3);
    drive(CLS_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd16);
    tick();
    check("t3_jal", imem_wdata, 32'h010000EF);
    drive(CLS_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000);
    tick();
    check("t3_lui", imem_wdata, 32'h123452B7);
    check("t3_lui_addr", 32'(imem_addr), 32'h041);
    drive(CLS_I_ALU, 5'd1, 5'd2, 5'd0, 3'b101, 1'b1, 32'h00000FE3);
    tick(); in_valid = 1'b0;
    check("t3_srai", imem_wdata, 32'h40315093);
    tick();
    check("t3_done", 32'(done), 32'd1);
    tick();

    // Illegal class mid-stream; JALR forces funct3 to 000
    begin_session(10'h050, 10'd2);
    drive(CLS_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0);
    tick();
    check("t4_addr0", 32'(imem_addr), 32'h050);
    drive(4'd15, 5'd7, 5'd7, 5'd7, 3'b111, 1'b1, 32'hFFFFFFFF);
    tick();
    check("t4_ill_we", 32'(imem_we), 32'd0);
    check("t4_ill_err", 32'(err_illegal), 32'd1);
    check("t4_ill_ready", 32'(in_ready), 32'd1);
    drive(CLS_JALR, 5'd1, 5'd5, 5'd0, 3'b111, 1'b0, 32'd4);
    tick(); in_valid = 1'b0;
    check("t4_jalr_we", 32'(imem_we), 32'd1);
    check("t4_jalr_addr", 32'(imem_addr), 32'h051);
    check("t4_jalr", imem_wdata, 32'h004280E7);
    tick();
    check("t4_done", 32'(done), 32'd1);
    check("t4_err_sticky", 32'(err_illegal), 32'd1);
    tick();
    begin_session(10'h000, 10'd0);
    check("t4_cnt0_done", 32'(done), 32'd1);
    check("t4_err_clr", 32'(err_illegal), 32'd0);
    tick();
    check("t4_cnt0_idle", 32'(busy), 32'd0);

    // Address wrap; start during LOAD is ignored
    begin_session(10'h3FF, 10'd2);
    drive(CLS_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0);
    start = 1'b1; base_addr = 10'h123; count = 10'd5;
    tick(); start = 1'b0;
    check("t5_addr0", 32'(imem_addr), 32'h3FF);
    drive(CLS_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000);
    tick(); in_valid = 1'b0;
    check("t5_addr1", 32'(imem_addr), 32'h000);
    check("t5_we1", 32'(imem_we), 32'd1);
    tick();
    check("t5_done", 32'(done), 32'd1);
    tick();
    check("t5_idle", 32'(dbg_state), 32'(S_IDLE));

    // Reset during LOAD drops the pending write
    begin_session(10'h100, 10'd3);
    drive(CLS_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0);
    tick(); in_valid = 1'b0;
    check("t6_pending", 32'(imem_we), 32'd1);
    reset = 1'b1;
    tick();
    check("t6_we", 32'(imem_we), 32'd0);
    check("t6_addr", 32'(imem_addr), 32'd0);
    check("t6_wdata", imem_wdata, 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ready", 32'(in_ready), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b0;
    tick();

`ifdef ENCODER_IMM_CHECK_EN
    begin_session(10'h200, 10'd2);
    drive(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8);
    tick();
    check("t7_range_ok", 32'(err_range), 32'd0);
    drive(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3);
    tick(); in_valid = 1'b0;
    check("t7_range_set", 32'(err_range), 32'd1);
    check("t7_range_we", 32'(imem_we), 32'd1);
    tick(); tick();
    begin_session(10'h000, 10'd0);
    check("t7_range_clr", 32'(err_range), 32'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
